// File: rtl/mux_seq_gen.sv
// Successor sequencer/mux for the VPU butterfly: issues a0/a1 or b0 reads, interleaves the
// returned lanes onto the o1/o2 groups and tags beats that lie in the negate region.
module mux_seq_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANES      = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BRAM_LAT   = 2,
  parameter int unsigned URAM_LAT   = 5,
  parameter int unsigned ALIGN_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic                        i_start,
  input  logic                        i_mode,
  input  logic [3:0]                  i_n,
  input  logic [ADDR_WIDTH:0]         i_len,
  input  logic [ALIGN_W-1:0]          i_align,
  input  logic [LANES*DATA_WIDTH-1:0] i_data_a0,
  input  logic [LANES*DATA_WIDTH-1:0] i_data_a1,
  input  logic [LANES*DATA_WIDTH-1:0] i_data_b0,
  input  logic [LANES*DATA_WIDTH-1:0] i_data_c1,
  output logic [ADDR_WIDTH-1:0]       o_addr_a0,
  output logic [ADDR_WIDTH-1:0]       o_addr_a1,
  output logic [ADDR_WIDTH-1:0]       o_addr_b0,
  output logic                        o_en_bram_a0,
  output logic                        o_en_bram_a1,
  output logic                        o_en_bram_b0,
  output logic [LANES*DATA_WIDTH-1:0] o_data_o1,
  output logic [LANES*DATA_WIDTH-1:0] o_data_o2,
  output logic [3:0]                  o_n,
  output logic                        o_valid,
  output logic                        o_negate,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned HALF    = DEPTH / 2;
  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned BUS_W   = LANES * DATA_WIDTH;
  localparam int unsigned MAX_LAT = (BRAM_LAT > URAM_LAT) ? BRAM_LAT : URAM_LAT;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] A1_BASE = ADDR_WIDTH'(HALF);

  typedef enum logic [1:0] {IDLE, ALIGN, ISSUE, DRAIN} state_t;

  state_t             state;
  logic               mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   k;
  logic [ALIGN_W-1:0] cnt_align;
  logic [LAT_W-1:0]   cnt_drain;
  logic [MAX_LAT-1:0] vpipe;
  logic [LEN_W-1:0]   ktag [MAX_LAT];

  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   thr;
  logic [LAT_W-1:0]   lat_sel;
  logic               v_tap;
  logic [LEN_W-1:0]   k_tap;
  logic               issue;
  logic [BUS_W-1:0]   x_bus, y_bus, o1_c, o2_c;

  assign lat_sel = mode_q ? LAT_W'(URAM_LAT) : LAT_W'(BRAM_LAT);
  assign issue   = o_en_bram_a0 | o_en_bram_b0;

  // Mode 0 can only walk the lower half of the BRAM pair.
  always_comb begin
    len_c = i_len;
    if (!i_mode && (i_len > LEN_W'(HALF))) len_c = LEN_W'(HALF);
  end

  // Negate threshold saturates at one beat for small transforms.
  always_comb begin
    if (32'(o_n) >= ADDR_WIDTH) thr = LEN_W'(1);
    else                        thr = LEN_W'(DEPTH >> o_n);
  end

  // Pick the pipeline stage that lines up with the active memory latency.
  always_comb begin
    v_tap = 1'b0;
    k_tap = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (LAT_W'(i + 1) == lat_sel) begin
        v_tap = vpipe[i];
        k_tap = ktag[i];
      end
    end
  end

  // Lane interleave: even lanes go to o1, odd lanes to o2, X/Y alternating.
  always_comb begin
    x_bus = mode_q ? i_data_b0 : i_data_a0;
    y_bus = mode_q ? i_data_c1 : i_data_a1;
    o1_c  = '0;
    o2_c  = '0;
    for (int j = 0; j < LANES / 2; j++) begin
      o1_c[(2*j)*DATA_WIDTH   +: DATA_WIDTH] = x_bus[(2*j)*DATA_WIDTH   +: DATA_WIDTH];
      o1_c[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = y_bus[(2*j)*DATA_WIDTH   +: DATA_WIDTH];
      o2_c[(2*j)*DATA_WIDTH   +: DATA_WIDTH] = x_bus[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
      o2_c[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = y_bus[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      len_q        <= '0;
      k            <= '0;
      cnt_align    <= '0;
      cnt_drain    <= '0;
      vpipe        <= '0;
      for (int i = 0; i < MAX_LAT; i++) ktag[i] <= '0;
      o_addr_a0    <= '0;
      o_addr_a1    <= A1_BASE;
      o_addr_b0    <= '0;
      o_en_bram_a0 <= 1'b0;
      o_en_bram_a1 <= 1'b0;
      o_en_bram_b0 <= 1'b0;
      o_data_o1    <= '0;
      o_data_o2    <= '0;
      o_n          <= '0;
      o_valid      <= 1'b0;
      o_negate     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else if (!i_en) begin
      // Flush: abandon the transfer, keep the last output data.
      state        <= IDLE;
      vpipe        <= '0;
      o_addr_a0    <= '0;
      o_addr_a1    <= A1_BASE;
      o_addr_b0    <= '0;
      o_en_bram_a0 <= 1'b0;
      o_en_bram_a1 <= 1'b0;
      o_en_bram_b0 <= 1'b0;
      o_valid      <= 1'b0;
      o_negate     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      vpipe[0] <= issue;
      ktag[0]  <= k;
      for (int i = 1; i < MAX_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        ktag[i]  <= ktag[i-1];
      end
      o_valid   <= v_tap;
      o_negate  <= v_tap && (k_tap < thr);
      o_data_o1 <= o1_c;
      o_data_o2 <= o2_c;
      o_done    <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start && (i_len != '0)) begin
            mode_q <= i_mode;
            o_n    <= i_n;
            len_q  <= len_c;
            k      <= '0;
            o_busy <= 1'b1;
            if (!i_mode) begin
              state        <= ISSUE;
              o_en_bram_a0 <= 1'b1;
              o_en_bram_a1 <= 1'b1;
            end else if (i_align == '0) begin
              state        <= ISSUE;
              o_en_bram_b0 <= 1'b1;
            end else begin
              state     <= ALIGN;
              cnt_align <= i_align - ALIGN_W'(1);
            end
          end
        end
        ALIGN: begin
          if (cnt_align == '0) begin
            state        <= ISSUE;
            o_en_bram_b0 <= 1'b1;
          end else begin
            cnt_align <= cnt_align - ALIGN_W'(1);
          end
        end
        ISSUE: begin
          if (k == len_q - LEN_W'(1)) begin
            state        <= DRAIN;
            cnt_drain    <= lat_sel;
            o_en_bram_a0 <= 1'b0;
            o_en_bram_a1 <= 1'b0;
            o_en_bram_b0 <= 1'b0;
            o_addr_a0    <= '0;
            o_addr_a1    <= A1_BASE;
            o_addr_b0    <= '0;
          end else begin
            k <= k + LEN_W'(1);
            if (!mode_q) begin
              o_addr_a0 <= ADDR_WIDTH'(k + LEN_W'(1));
              o_addr_a1 <= A1_BASE + ADDR_WIDTH'(k + LEN_W'(1));
            end else begin
              o_addr_b0 <= ADDR_WIDTH'(k + LEN_W'(1));
            end
          end
        end
        DRAIN: begin
          if (cnt_drain == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            cnt_drain <= cnt_drain - LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_seq_gen.sv
// Bench for mux_seq_gen: a latency-accurate memory model feeds the DUT, a scoreboard queue
// holds expected beats, and a negedge monitor checks enables, addresses, data and done.
module tb_mux_seq_gen;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned DW       = 64;
  localparam int unsigned LANES    = 4;
  localparam int unsigned AW       = 12;
  localparam int unsigned BRAM_LAT = 2;
  localparam int unsigned URAM_LAT = 5;
  localparam int unsigned ALW      = 4;
  localparam int unsigned BW       = LANES * DW;
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned HALF     = DEPTH / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en, i_start, i_mode;
  logic [3:0]    i_n;
  logic [LW-1:0] i_len;
  logic [ALW-1:0] i_align;
  logic [BW-1:0] i_data_a0, i_data_a1, i_data_b0, i_data_c1;
  logic [AW-1:0] o_addr_a0, o_addr_a1, o_addr_b0;
  logic          o_en_bram_a0, o_en_bram_a1, o_en_bram_b0;
  logic [BW-1:0] o_data_o1, o_data_o2;
  logic [3:0]    o_n;
  logic          o_valid, o_negate, o_busy, o_done;

  mux_seq_gen #(
    .DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW),
    .BRAM_LAT(BRAM_LAT), .URAM_LAT(URAM_LAT), .ALIGN_W(ALW)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_start(i_start), .i_mode(i_mode),
    .i_n(i_n), .i_len(i_len), .i_align(i_align),
    .i_data_a0(i_data_a0), .i_data_a1(i_data_a1), .i_data_b0(i_data_b0), .i_data_c1(i_data_c1),
    .o_addr_a0(o_addr_a0), .o_addr_a1(o_addr_a1), .o_addr_b0(o_addr_b0),
    .o_en_bram_a0(o_en_bram_a0), .o_en_bram_a1(o_en_bram_a1), .o_en_bram_b0(o_en_bram_b0),
    .o_data_o1(o_data_o1), .o_data_o2(o_data_o2), .o_n(o_n),
    .o_valid(o_valid), .o_negate(o_negate), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    int         len;
    logic [3:0] n;
    int         align;
    int         beats;
    int         en_off;
    int         last_x;
    int         last_a1;
  } vec_t;

  typedef struct {
    logic [BW-1:0] o1;
    logic [BW-1:0] o2;
    logic          neg;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0, n_bad = 0;
  int    cyc = 0;
  int    en_cnt = 0, en_first = 0, done_cnt = 0, done_cyc = 0;
  int    last_x = 0, last_a1 = 0;
  logic  cur_mode = 1'b0;

  function automatic logic [BW-1:0] mk(input logic [7:0] tag, input int unsigned addr);
    logic [BW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = {tag, 8'(l), 16'h0, 32'(addr)};
    return r;
  endfunction

  function automatic void chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory model: address captured with the enable cycle, data presented LAT cycles later.
  logic [AW-1:0] h_a0 [BRAM_LAT];
  logic [AW-1:0] h_a1 [BRAM_LAT];
  logic [AW-1:0] h_b0 [URAM_LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    h_a0[0] <= o_addr_a0;
    h_a1[0] <= o_addr_a1;
    h_b0[0] <= o_addr_b0;
    for (int i = 1; i < BRAM_LAT; i++) begin
      h_a0[i] <= h_a0[i-1];
      h_a1[i] <= h_a1[i-1];
    end
    for (int i = 1; i < URAM_LAT; i++) h_b0[i] <= h_b0[i-1];
  end

  assign i_data_a0 = mk(8'hA0, 32'(h_a0[BRAM_LAT-1]));
  assign i_data_a1 = mk(8'hA1, 32'(h_a1[BRAM_LAT-1]));
  assign i_data_b0 = mk(8'hB0, 32'(h_b0[URAM_LAT-1]));
  assign i_data_c1 = mk(8'hC1, 32'(h_b0[URAM_LAT-1]));

  function automatic beat_t exp_beat(input logic mode, input int k, input logic neg, input int c);
    beat_t         b;
    logic [BW-1:0] x, y;
    x = mode ? mk(8'hB0, k) : mk(8'hA0, k);
    y = mode ? mk(8'hC1, k) : mk(8'hA1, HALF + k);
    b.o1 = '0;
    b.o2 = '0;
    for (int j = 0; j < LANES / 2; j++) begin
      b.o1[(2*j)*DW   +: DW] = x[(2*j)*DW   +: DW];
      b.o1[(2*j+1)*DW +: DW] = y[(2*j)*DW   +: DW];
      b.o2[(2*j)*DW   +: DW] = x[(2*j+1)*DW +: DW];
      b.o2[(2*j+1)*DW +: DW] = y[(2*j+1)*DW +: DW];
    end
    b.neg = neg;
    b.cyc = c;
    return b;
  endfunction

  // Monitor: scoreboard pops on o_valid, issue pattern and address sequence on every enable.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", BW'(o_valid), BW'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("valid_cycle", BW'(cyc), BW'(e.cyc));
          chk("data_o1", o_data_o1, e.o1);
          chk("data_o2", o_data_o2, e.o2);
          chk("negate", BW'(o_negate), BW'(e.neg));
        end
      end else begin
        chk("negate_without_valid", BW'(o_negate), BW'(0));
      end
      if (o_en_bram_a0 || o_en_bram_a1 || o_en_bram_b0) begin
        if (en_cnt == 0) en_first = cyc;
        if (cur_mode) begin
          chk("en_pattern_m1", BW'({o_en_bram_a0, o_en_bram_a1, o_en_bram_b0}), BW'(3'b001));
          chk("addr_b0_seq", BW'(o_addr_b0), BW'(AW'(en_cnt)));
          last_x = int'(o_addr_b0);
        end else begin
          chk("en_pattern_m0", BW'({o_en_bram_a0, o_en_bram_a1, o_en_bram_b0}), BW'(3'b110));
          chk("addr_a0_seq", BW'(o_addr_a0), BW'(AW'(en_cnt)));
          chk("addr_a1_seq", BW'(o_addr_a1), BW'(AW'(HALF + en_cnt)));
          last_x  = int'(o_addr_a0);
          last_a1 = int'(o_addr_a1);
        end
        en_cnt++;
      end else begin
        chk("idle_addr", BW'({o_addr_a0, o_addr_a1, o_addr_b0}), BW'({AW'(0), AW'(HALF), AW'(0)}));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, BW'({o_addr_a0, o_addr_a1, o_addr_b0}), BW'({AW'(0), AW'(HALF), AW'(0)}));
    chk({tag, "_flags"}, BW'({o_en_bram_a0, o_en_bram_a1, o_en_bram_b0, o_valid, o_negate, o_busy, o_done}), BW'(0));
    chk({tag, "_n"}, BW'(o_n), BW'(0));
    chk({tag, "_o1"}, o_data_o1, BW'(0));
    chk({tag, "_o2"}, o_data_o2, BW'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int s, lat, thr, base, exp_done;
    bit got;
    @(negedge clk); #1;
    exp_q.delete();
    s        = cyc;
    cur_mode = v.mode;
    en_cnt   = 0;
    base     = done_cnt;
    lat      = v.mode ? URAM_LAT : BRAM_LAT;
    thr      = (int'(v.n) >= int'(AW)) ? 1 : int'(DEPTH >> v.n);
    for (int k = 0; k < v.beats; k++)
      exp_q.push_back(exp_beat(v.mode, k, (k < thr), s + v.en_off + k + lat + 1));
    i_mode  = v.mode;
    i_len   = LW'(v.len);
    i_n     = v.n;
    i_align = ALW'(v.align);
    i_start = 1'b1;
    @(negedge clk); #1;
    chk("busy_after_start", BW'(o_busy), BW'(1));
    chk("n_latched", BW'(o_n), BW'(v.n));
    // A second start while busy must leave the transfer untouched.
    i_mode  = ~v.mode;
    i_len   = LW'(3);
    i_n     = v.n ^ 4'hF;
    i_align = '0;
    @(negedge clk); #1;
    i_start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < v.beats + v.align + 40 && !got; c++) begin
      @(negedge clk); #1;
      if (done_cnt != base) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: no o_done for len %0d mode %0d", v.len, v.mode);
    end else begin
      exp_done = s + v.en_off + v.beats - 1 + lat + 2;
      chk("done_cycle", BW'(done_cyc), BW'(exp_done));
      chk("busy_at_done", BW'(o_busy), BW'(0));
      chk("en_first", BW'(en_first), BW'(s + v.en_off));
      chk("en_count", BW'(en_cnt), BW'(v.beats));
      chk("last_addr", BW'(last_x), BW'(v.last_x));
      if (!v.mode) chk("last_a1", BW'(last_a1), BW'(v.last_a1));
      chk("queue_drained", BW'(exp_q.size()), BW'(0));
      @(negedge clk); #1;
      chk("done_width", BW'(o_done), BW'(0));
      chk("done_count", BW'(done_cnt - base), BW'(1));
    end
  endtask

  vec_t tab [9];

  initial begin
    // mode, len, n, align, beats, en_off, last_x, last_a1
    tab[0] = '{1'b0,    8, 4'd0,  0,    8,  1,    7, 2055};
    tab[1] = '{1'b1,    4, 4'd0,  7,    4,  8,    3,    0};
    tab[2] = '{1'b0,   16, 4'd9,  0,   16,  1,   15, 2063};
    tab[3] = '{1'b1,    6, 4'd12, 0,    6,  1,    5,    0};
    tab[4] = '{1'b1,    3, 4'd15, 3,    3,  4,    2,    0};
    tab[5] = '{1'b0, 4096, 4'd11, 5, 2048,  1, 2047, 4095};
    tab[6] = '{1'b1,    1, 4'd2,  1,    1,  2,    0,    0};
    tab[7] = '{1'b0,    1, 4'd4,  0,    1,  1,    0, 2048};
    tab[8] = '{1'b1,   20, 4'd10, 15,  20, 16,   19,    0};

    for (int i = 0; i < BRAM_LAT; i++) begin
      h_a0[i] = '0;
      h_a1[i] = '0;
    end
    for (int i = 0; i < URAM_LAT; i++) h_b0[i] = '0;

    rst = 1'b1; i_en = 1'b1; i_start = 1'b0; i_mode = 1'b0;
    i_n = '0; i_len = '0; i_align = '0;
    @(negedge clk); #1;
    chk_reset("reset_init");
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tab[i]);

    // Zero-length start is ignored.
    begin
      int base;
      @(negedge clk); #1;
      base = done_cnt; cur_mode = 1'b0; en_cnt = 0;
      i_mode = 1'b0; i_len = '0; i_n = 4'd1; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      chk("len0_busy", BW'(o_busy), BW'(0));
      chk("len0_en", BW'({o_en_bram_a0, o_en_bram_a1, o_en_bram_b0}), BW'(0));
      repeat (10) @(negedge clk);
      #1;
      chk("len0_no_done", BW'(done_cnt - base), BW'(0));
      chk("len0_no_issue", BW'(en_cnt), BW'(0));
    end

    // Flush in the middle of ISSUE.
    begin
      int s, base;
      logic [BW-1:0] held;
      @(negedge clk); #1;
      exp_q.delete();
      s = cyc; base = done_cnt; cur_mode = 1'b0; en_cnt = 0;
      for (int k = 0; k < 16; k++) exp_q.push_back(exp_beat(1'b0, k, (k < 4096), s + 1 + k + BRAM_LAT + 1));
      i_mode = 1'b0; i_len = LW'(16); i_n = 4'd0; i_align = '0; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("flush_pre_busy", BW'(o_busy), BW'(1));
      held = o_data_o1;
      i_en = 1'b0;
      @(negedge clk); #1;
      chk("flush_en", BW'({o_en_bram_a0, o_en_bram_a1, o_en_bram_b0}), BW'(0));
      chk("flush_valid", BW'(o_valid), BW'(0));
      chk("flush_busy", BW'(o_busy), BW'(0));
      chk("flush_hold_o1", o_data_o1, held);
      exp_q.delete();
      i_en = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      chk("flush_no_done", BW'(done_cnt - base), BW'(0));
      run_vec(tab[0]);
    end

    // Reset while draining.
    begin
      int base;
      @(negedge clk); #1;
      exp_q.delete();
      base = done_cnt; cur_mode = 1'b1; en_cnt = 0;
      i_mode = 1'b1; i_len = LW'(4); i_n = 4'd3; i_align = '0; i_start = 1'b1;
      @(negedge clk); #1;
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("drain_busy", BW'(o_busy), BW'(1));
      chk("drain_issued", BW'(en_cnt), BW'(4));
      rst = 1'b1;
      #1;
      chk_reset("reset_mid_drain");
      @(negedge clk); rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("reset_no_done", BW'(done_cnt - base), BW'(0));
      run_vec(tab[3]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
